opendap_sw_dp_regs: RTL and testbench
=====================================

# opendap_sw_dp_regs

SW-DP register file and AP access launcher, directly downstream of the SW-DP serial link layer. Decodes the link layer's parallel DP/AP accesses, implements DPIDR/ABORT, CTRL/STAT, SELECT, RDBUFF and the banked DP registers, and maintains the sticky error flags. Posts AP reads and writes to the AP mux over a req/ack handshake. Returns ready, sticky and protocol-error status to the link layer for ACK generation.

## Interface
- DPIDR, 32'h4ba02477: DPIDR read value.
- DLPIDR, 32'h00000001: DLPIDR read value (bank 3).
- swclk  in  1  debug clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- bus_addr  in  2  register address A[3:2].
- bus_ap_ndp  in  1  1 = AP access, 0 = DP access.
- bus_r_nw  in  1  1 = read; valid alongside bus_ren/bus_wen.
- bus_wdata  in  32  write data; valid with bus_wen.
- bus_wen  in  1  one-cycle write strobe (parity already checked).
- bus_ren  in  1  one-cycle access-start strobe, asserted for every OK-acked access, reads and writes.
- bus_rdata  out  32  registered read data.
- targetid  in  32  TARGETID value (bank 2).
- dp_set_wdataerr, dp_set_stickyorun  in  1  set WDATAERR / STICKYORUN.
- dp_orundetect  out  1  CTRL/STAT.ORUNDETECT.
- dp_any_sticky_err  out  1  OR of STICKYORUN, STICKYCMP, STICKYERR, WDATAERR.
- dp_acc_protocol_err  out  1  combinational: current access illegal.
- ap_rdy  out  1  no AP transfer outstanding.
- ap_req  out  1  AP transfer request, held until ap_ack.
- ap_wen  out  1  1 = AP write.
- ap_sel  out  8  SELECT.APSEL.
- ap_addr  out  6  {APBANKSEL, bus_addr}.
- ap_wdata  out  32  AP write data.
- ap_rdata  in  32  AP read data, valid with ap_ack.
- ap_ack, ap_err  in  1  transfer complete; error response.
- ap_abort  out  1  one-cycle DAPABORT pulse.
- cdbgpwrupreq, csyspwrupreq  out  1  power-up requests.
- cdbgpwrupack, csyspwrupack  in  1  power-up acknowledges.

## Operation
- DP A=0: read DPIDR; write ABORT: bit0 pulses ap_abort, bits 1..4 clear STICKYCMP, STICKYERR, WDATAERR, STICKYORUN respectively.
- DP A=4, by SELECT.DPBANKSEL: 0 CTRL/STAT, 1 DLCR (reads 0), 2 TARGETID, 3 DLPIDR, 4 EVENTSTAT (reads 1). Writes to banks 1-4 ignored.
- CTRL/STAT: [0] ORUNDETECT rw, [1] STICKYORUN, [4] STICKYCMP, [5] STICKYERR, [7] WDATAERR (ro, clear via ABORT only), [28] CDBGPWRUPREQ rw, [29] CDBGPWRUPACK ro, [30] CSYSPWRUPREQ rw, [31] CSYSPWRUPACK ro; other bits read 0.
- DP A=8: write SELECT ([31:24] APSEL, [7:4] APBANKSEL, [3:0] DPBANKSEL); read RESEND: bus_rdata not updated.
- DP A=C: read RDBUFF; write ignored (TARGETSEL handled upstream).
- AP read: on bus_ren & bus_r_nw, bus_rdata <= RDBUFF (posted result); launch read. AP write: launch on bus_wen.
- Launch: ap_req=1, ap_wen/ap_sel/ap_addr/ap_wdata latched; ap_rdy=0. On ap_ack: ap_req=0, ap_rdy=1; reads load RDBUFF <= ap_rdata; ap_err sets STICKYERR.
- dp_acc_protocol_err = bus_ren & !bus_ap_ndp & bus_addr==1 & DPBANKSEL>4. Depends only on bus_* and SELECT; never on ap_rdy or sticky state.
- DAPABORT: ap_req=0, ap_rdy=1 next cycle; a coinciding ap_ack is discarded.
- rst_n is the only reset; line reset/dormant do not clear registers.

## Timing
- Reset: all registers, bus_rdata, RDBUFF, SELECT, CTRL/STAT 0; ap_req, ap_abort, pwrup reqs 0; ap_rdy 1.
- bus_rdata updates on the edge sampling bus_ren, holds until next read.
- ap_req rises the edge after bus_ren/bus_wen; earliest ap_ack one cycle after ap_req high.
- Same-cycle set and ABORT clear of a sticky flag: set wins.

## Configuration
- OPENDAP_DP_PWRUP_SYNC_EN defined: cdbgpwrupack/csyspwrupack pass through 2-flop synchronisers (reset 0) before CTRL/STAT; 2-cycle extra latency.
- Undefined: acks read directly, assumed synchronous to swclk.

## Test plan
- Read DP A=0 after reset -> bus_rdata=32'h4ba02477, dp_any_sticky_err=0.
- Write SELECT=32'h0000_0002, read DP A=4 with targetid=32'h01002927 -> bus_rdata=32'h01002927; SELECT DPBANKSEL=5, read A=4 -> dp_acc_protocol_err=1.
- AP read A=0xC, ap_ack with ap_rdata=32'hdeadbeef after 3 cycles -> ap_rdy low 4 cycles, then read RDBUFF=32'hdeadbeef.
- AP write with ap_err=1 on ack -> CTRL/STAT[5]=1, dp_any_sticky_err=1; ABORT write 32'h4 -> cleared.
- Pulse dp_set_stickyorun and ABORT bit4 in same cycle -> STICKYORUN remains 1.
- Write CTRL/STAT 32'h50000000, ack inputs high -> readback 32'hf0000000 (macro defined: only after 2 extra cycles).

Source files
------------

// File: rtl/opendap_sw_dp_regs.sv
// SW-DP register file and AP access launcher behind the serial link layer.
// Define OPENDAP_DP_PWRUP_SYNC_EN to pass the power-up acks through 2-flop synchronisers.
module opendap_sw_dp_regs #(
  parameter logic [31:0] DPIDR  = 32'h4ba02477,
  parameter logic [31:0] DLPIDR = 32'h00000001
) (
  input  logic        swclk,
  input  logic        rst_n,
  input  logic [1:0]  bus_addr,
  input  logic        bus_ap_ndp,
  input  logic        bus_r_nw,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  input  logic [31:0] targetid,
  input  logic        dp_set_wdataerr,
  input  logic        dp_set_stickyorun,
  output logic        dp_orundetect,
  output logic        dp_any_sticky_err,
  output logic        dp_acc_protocol_err,
  output logic        ap_rdy,
  output logic        ap_req,
  output logic        ap_wen,
  output logic [7:0]  ap_sel,
  output logic [5:0]  ap_addr,
  output logic [31:0] ap_wdata,
  input  logic [31:0] ap_rdata,
  input  logic        ap_ack,
  input  logic        ap_err,
  output logic        ap_abort,
  output logic        cdbgpwrupreq,
  output logic        csyspwrupreq,
  input  logic        cdbgpwrupack,
  input  logic        csyspwrupack
);

  logic [7:0]  apsel_q, apsel_d;
  logic [3:0]  apbanksel_q, apbanksel_d;
  logic [3:0]  dpbanksel_q, dpbanksel_d;
  logic        orundetect_q, orundetect_d;
  logic        stickyorun_q, stickyorun_d;
  logic        stickycmp_q, stickycmp_d;
  logic        stickyerr_q, stickyerr_d;
  logic        wdataerr_q, wdataerr_d;
  logic        cdbgreq_q, cdbgreq_d;
  logic        csysreq_q, csysreq_d;
  logic [31:0] rdbuff_q, rdbuff_d;
  logic [31:0] bus_rdata_q, bus_rdata_d;
  logic        ap_req_q, ap_req_d;
  logic        ap_wen_q, ap_wen_d;
  logic [7:0]  ap_sel_q, ap_sel_d;
  logic [5:0]  ap_addr_q, ap_addr_d;
  logic [31:0] ap_wdata_q, ap_wdata_d;
  logic        ap_abort_q, ap_abort_d;

  logic        cdbg_ack, csys_ack;
  logic        dp_rd, dp_wr, ap_rd, ap_wr, abort_wr, ack_ok;
  logic [31:0] ctrl_stat;

`ifdef OPENDAP_DP_PWRUP_SYNC_EN
  logic [1:0] cdbg_sync_q, cdbg_sync_d;
  logic [1:0] csys_sync_q, csys_sync_d;

  always_comb begin
    cdbg_sync_d = {cdbg_sync_q[0], cdbgpwrupack};
    csys_sync_d = {csys_sync_q[0], csyspwrupack};
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      cdbg_sync_q <= 2'b00;
      csys_sync_q <= 2'b00;
    end else begin
      cdbg_sync_q <= cdbg_sync_d;
      csys_sync_q <= csys_sync_d;
    end
  end

  assign cdbg_ack = cdbg_sync_q[1];
  assign csys_ack = csys_sync_q[1];
`else
  assign cdbg_ack = cdbgpwrupack;
  assign csys_ack = csyspwrupack;
`endif

  assign ctrl_stat = {csys_ack, csysreq_q, cdbg_ack, cdbgreq_q, 20'h0,
                      wdataerr_q, 1'b0, stickyerr_q, stickycmp_q, 2'b00,
                      stickyorun_q, orundetect_q};

  // Illegal DP bank select is a pure decode of the access and SELECT.
  assign dp_acc_protocol_err = bus_ren & ~bus_ap_ndp & (bus_addr == 2'd1) &
                               (dpbanksel_q > 4'd4);

  always_comb begin
    dp_rd    = bus_ren & bus_r_nw & ~bus_ap_ndp;
    dp_wr    = bus_wen & ~bus_ap_ndp;
    ap_rd    = bus_ren & bus_r_nw & bus_ap_ndp;
    ap_wr    = bus_wen & bus_ap_ndp;
    abort_wr = dp_wr & (bus_addr == 2'd0);
    ap_abort_d = abort_wr & bus_wdata[0];
    // An ack landing in the same cycle as DAPABORT belongs to the aborted transfer.
    ack_ok   = ap_req_q & ap_ack & ~ap_abort_d;

    apsel_d      = apsel_q;
    apbanksel_d  = apbanksel_q;
    dpbanksel_d  = dpbanksel_q;
    orundetect_d = orundetect_q;
    cdbgreq_d    = cdbgreq_q;
    csysreq_d    = csysreq_q;
    rdbuff_d     = rdbuff_q;
    bus_rdata_d  = bus_rdata_q;
    ap_req_d     = ap_req_q;
    ap_wen_d     = ap_wen_q;
    ap_sel_d     = ap_sel_q;
    ap_addr_d    = ap_addr_q;
    ap_wdata_d   = ap_wdata_q;

    // Set has priority over an ABORT clear in the same cycle.
    stickycmp_d  = stickycmp_q & ~(abort_wr & bus_wdata[1]);
    stickyerr_d  = (stickyerr_q & ~(abort_wr & bus_wdata[2])) | (ack_ok & ap_err);
    wdataerr_d   = (wdataerr_q & ~(abort_wr & bus_wdata[3])) | dp_set_wdataerr;
    stickyorun_d = (stickyorun_q & ~(abort_wr & bus_wdata[4])) | dp_set_stickyorun;

    if (dp_wr && bus_addr == 2'd1 && dpbanksel_q == 4'd0) begin
      orundetect_d = bus_wdata[0];
      cdbgreq_d    = bus_wdata[28];
      csysreq_d    = bus_wdata[30];
    end
    if (dp_wr && bus_addr == 2'd2) begin
      apsel_d     = bus_wdata[31:24];
      apbanksel_d = bus_wdata[7:4];
      dpbanksel_d = bus_wdata[3:0];
    end

    if (dp_rd) begin
      case (bus_addr)
        2'd0: bus_rdata_d = DPIDR;
        2'd1: begin
          case (dpbanksel_q)
            4'd0:    bus_rdata_d = ctrl_stat;
            4'd2:    bus_rdata_d = targetid;
            4'd3:    bus_rdata_d = DLPIDR;
            4'd4:    bus_rdata_d = 32'h00000001;
            default: bus_rdata_d = 32'h0;
          endcase
        end
        2'd3:    bus_rdata_d = rdbuff_q;
        default: bus_rdata_d = bus_rdata_q;
      endcase
    end else if (ap_rd) begin
      bus_rdata_d = rdbuff_q;
    end

    if (ack_ok) begin
      ap_req_d = 1'b0;
      if (!ap_wen_q) rdbuff_d = ap_rdata;
    end
    if (ap_rd || ap_wr) begin
      ap_req_d   = 1'b1;
      ap_wen_d   = ap_wr;
      ap_sel_d   = apsel_q;
      ap_addr_d  = {apbanksel_q, bus_addr};
      ap_wdata_d = bus_wdata;
    end
    if (ap_abort_d) ap_req_d = 1'b0;
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      apsel_q      <= '0;
      apbanksel_q  <= '0;
      dpbanksel_q  <= '0;
      orundetect_q <= 1'b0;
      stickyorun_q <= 1'b0;
      stickycmp_q  <= 1'b0;
      stickyerr_q  <= 1'b0;
      wdataerr_q   <= 1'b0;
      cdbgreq_q    <= 1'b0;
      csysreq_q    <= 1'b0;
      rdbuff_q     <= '0;
      bus_rdata_q  <= '0;
      ap_req_q     <= 1'b0;
      ap_wen_q     <= 1'b0;
      ap_sel_q     <= '0;
      ap_addr_q    <= '0;
      ap_wdata_q   <= '0;
      ap_abort_q   <= 1'b0;
    end else begin
      apsel_q      <= apsel_d;
      apbanksel_q  <= apbanksel_d;
      dpbanksel_q  <= dpbanksel_d;
      orundetect_q <= orundetect_d;
      stickyorun_q <= stickyorun_d;
      stickycmp_q  <= stickycmp_d;
      stickyerr_q  <= stickyerr_d;
      wdataerr_q   <= wdataerr_d;
      cdbgreq_q    <= cdbgreq_d;
      csysreq_q    <= csysreq_d;
      rdbuff_q     <= rdbuff_d;
      bus_rdata_q  <= bus_rdata_d;
      ap_req_q     <= ap_req_d;
      ap_wen_q     <= ap_wen_d;
      ap_sel_q     <= ap_sel_d;
      ap_addr_q    <= ap_addr_d;
      ap_wdata_q   <= ap_wdata_d;
      ap_abort_q   <= ap_abort_d;
    end
  end

  assign bus_rdata         = bus_rdata_q;
  assign dp_orundetect     = orundetect_q;
  assign dp_any_sticky_err = stickyorun_q | stickycmp_q | stickyerr_q | wdataerr_q;
  assign ap_rdy            = ~ap_req_q;
  assign ap_req            = ap_req_q;
  assign ap_wen            = ap_wen_q;
  assign ap_sel            = ap_sel_q;
  assign ap_addr           = ap_addr_q;
  assign ap_wdata          = ap_wdata_q;
  assign ap_abort          = ap_abort_q;
  assign cdbgpwrupreq      = cdbgreq_q;
  assign csyspwrupreq      = csysreq_q;

endmodule

// File: tb/tb_opendap_sw_dp_regs.sv
// Directed bench for opendap_sw_dp_regs: DP decode, AP launch/ack, sticky flags, abort, power-up.
// Inputs change and outputs are sampled on the falling edge of swclk.
module tb_opendap_sw_dp_regs;

  logic        swclk = 1'b0;
  logic        rst_n;
  logic [1:0]  bus_addr;
  logic        bus_ap_ndp;
  logic        bus_r_nw;
  logic [31:0] bus_wdata;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_rdata;
  logic [31:0] targetid;
  logic        dp_set_wdataerr;
  logic        dp_set_stickyorun;
  logic        dp_orundetect;
  logic        dp_any_sticky_err;
  logic        dp_acc_protocol_err;
  logic        ap_rdy;
  logic        ap_req;
  logic        ap_wen;
  logic [7:0]  ap_sel;
  logic [5:0]  ap_addr;
  logic [31:0] ap_wdata;
  logic [31:0] ap_rdata;
  logic        ap_ack;
  logic        ap_err;
  logic        ap_abort;
  logic        cdbgpwrupreq;
  logic        csyspwrupreq;
  logic        cdbgpwrupack;
  logic        csyspwrupack;

  int errors = 0;
  int checks = 0;

  opendap_sw_dp_regs dut (
    .swclk(swclk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_ap_ndp(bus_ap_ndp), .bus_r_nw(bus_r_nw),
    .bus_wdata(bus_wdata), .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_rdata(bus_rdata), .targetid(targetid),
    .dp_set_wdataerr(dp_set_wdataerr), .dp_set_stickyorun(dp_set_stickyorun),
    .dp_orundetect(dp_orundetect), .dp_any_sticky_err(dp_any_sticky_err),
    .dp_acc_protocol_err(dp_acc_protocol_err),
    .ap_rdy(ap_rdy), .ap_req(ap_req), .ap_wen(ap_wen), .ap_sel(ap_sel),
    .ap_addr(ap_addr), .ap_wdata(ap_wdata), .ap_rdata(ap_rdata),
    .ap_ack(ap_ack), .ap_err(ap_err), .ap_abort(ap_abort),
    .cdbgpwrupreq(cdbgpwrupreq), .csyspwrupreq(csyspwrupreq),
    .cdbgpwrupack(cdbgpwrupack), .csyspwrupack(csyspwrupack)
  );

  always #5 swclk = ~swclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge swclk);
  endtask

  // One-cycle access-start strobe; a read when rnw=1.
  task automatic rd(input logic ap, input logic [1:0] a);
    bus_ap_ndp = ap; bus_addr = a; bus_r_nw = 1'b1; bus_ren = 1'b1;
    cyc();
    bus_ren = 1'b0;
  endtask

  // Access start followed by the write-data strobe on the next cycle.
  task automatic wr(input logic ap, input logic [1:0] a, input logic [31:0] d);
    bus_ap_ndp = ap; bus_addr = a; bus_r_nw = 1'b0; bus_ren = 1'b1;
    cyc();
    bus_ren = 1'b0; bus_wen = 1'b1; bus_wdata = d;
    cyc();
    bus_wen = 1'b0;
  endtask

  initial begin
    int lowcnt;
    rst_n = 1'b0;
    bus_addr = 2'd0; bus_ap_ndp = 1'b0; bus_r_nw = 1'b0; bus_wdata = 32'h0;
    bus_wen = 1'b0; bus_ren = 1'b0; targetid = 32'h01002927;
    dp_set_wdataerr = 1'b0; dp_set_stickyorun = 1'b0;
    ap_rdata = 32'h0; ap_ack = 1'b0; ap_err = 1'b0;
    cdbgpwrupack = 1'b0; csyspwrupack = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    chk("rst_ap_rdy", {31'h0, ap_rdy}, 32'h1);
    chk("rst_ap_req", {31'h0, ap_req}, 32'h0);
    chk("rst_bus_rdata", bus_rdata, 32'h0);
    chk("rst_pwrup_reqs", {30'h0, cdbgpwrupreq, csyspwrupreq}, 32'h0);
    chk("rst_ap_abort", {31'h0, ap_abort}, 32'h0);

    rd(1'b0, 2'd0);
    chk("dpidr", bus_rdata, 32'h4ba02477);
    chk("dpidr_sticky", {31'h0, dp_any_sticky_err}, 32'h0);

    wr(1'b0, 2'd2, 32'h0000_0002);
    rd(1'b0, 2'd1);
    chk("targetid", bus_rdata, 32'h01002927);
    wr(1'b0, 2'd2, 32'h0000_0003);
    rd(1'b0, 2'd1);
    chk("dlpidr", bus_rdata, 32'h00000001);
    wr(1'b0, 2'd2, 32'h0000_0001);
    rd(1'b0, 2'd1);
    chk("dlcr", bus_rdata, 32'h0);

    wr(1'b0, 2'd2, 32'h0000_0005);
    bus_ap_ndp = 1'b0; bus_addr = 2'd1; bus_r_nw = 1'b1; bus_ren = 1'b1;
    #1 chk("proto_err_bank5", {31'h0, dp_acc_protocol_err}, 32'h1);
    bus_ap_ndp = 1'b1;
    #1 chk("proto_err_ap", {31'h0, dp_acc_protocol_err}, 32'h0);
    bus_ren = 1'b0;
    cyc();

    // AP read with ack arriving after three idle cycles.
    wr(1'b0, 2'd2, 32'h0A00_00F0);
    rd(1'b1, 2'd3);
    chk("apr_posted", bus_rdata, 32'h0);
    chk("apr_fields", {ap_req, ap_wen, ap_sel, ap_addr}, {1'b1, 1'b0, 8'h0A, 6'h3F});
    lowcnt = ap_rdy ? 0 : 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (!ap_rdy) lowcnt++;
    end
    ap_ack = 1'b1; ap_rdata = 32'hdeadbeef;
    cyc();
    ap_ack = 1'b0;
    chk("apr_rdy_low_cycles", lowcnt, 32'd4);
    chk("apr_done", {30'h0, ap_req, ap_rdy}, 32'h1);
    rd(1'b0, 2'd3);
    chk("rdbuff", bus_rdata, 32'hdeadbeef);
    rd(1'b0, 2'd2);
    chk("resend_holds", bus_rdata, 32'hdeadbeef);

    // AP write completing with an error response.
    wr(1'b1, 2'd1, 32'h12345678);
    chk("apw_fields", {ap_req, ap_wen, ap_addr}, {1'b1, 1'b1, 6'h3D});
    chk("apw_wdata", ap_wdata, 32'h12345678);
    cyc();
    ap_ack = 1'b1; ap_err = 1'b1; ap_rdata = 32'h0badf00d;
    cyc();
    ap_ack = 1'b0; ap_err = 1'b0;
    wr(1'b0, 2'd2, 32'h0A00_00F0);
    rd(1'b0, 2'd1);
    chk("stickyerr_set", bus_rdata, 32'h00000020);
    chk("stickyerr_any", {31'h0, dp_any_sticky_err}, 32'h1);
    rd(1'b0, 2'd3);
    chk("apw_keeps_rdbuff", bus_rdata, 32'hdeadbeef);
    wr(1'b0, 2'd0, 32'h0000_0004);
    rd(1'b0, 2'd1);
    chk("stickyerr_clr", bus_rdata, 32'h0);
    chk("stickyerr_any_clr", {31'h0, dp_any_sticky_err}, 32'h0);

    // STICKYORUN set coinciding with its ABORT clear.
    bus_ap_ndp = 1'b0; bus_addr = 2'd0; bus_r_nw = 1'b0; bus_ren = 1'b1;
    cyc();
    bus_ren = 1'b0; bus_wen = 1'b1; bus_wdata = 32'h0000_0010; dp_set_stickyorun = 1'b1;
    cyc();
    bus_wen = 1'b0; dp_set_stickyorun = 1'b0;
    rd(1'b0, 2'd1);
    chk("orun_set_wins", bus_rdata, 32'h00000002);
    wr(1'b0, 2'd0, 32'h0000_0010);
    rd(1'b0, 2'd1);
    chk("orun_clr", bus_rdata, 32'h0);

    dp_set_wdataerr = 1'b1;
    cyc();
    dp_set_wdataerr = 1'b0;
    rd(1'b0, 2'd1);
    chk("wdataerr_set", bus_rdata, 32'h00000080);
    wr(1'b0, 2'd0, 32'h0000_0008);
    rd(1'b0, 2'd1);
    chk("wdataerr_clr", bus_rdata, 32'h0);

    // DAPABORT with a coinciding ack that must be discarded.
    rd(1'b1, 2'd0);
    chk("abt_launch", {31'h0, ap_req}, 32'h1);
    bus_ap_ndp = 1'b0; bus_addr = 2'd0; bus_r_nw = 1'b0; bus_ren = 1'b1;
    cyc();
    bus_ren = 1'b0; bus_wen = 1'b1; bus_wdata = 32'h0000_0001;
    ap_ack = 1'b1; ap_err = 1'b1; ap_rdata = 32'h55555555;
    cyc();
    bus_wen = 1'b0; ap_ack = 1'b0; ap_err = 1'b0;
    chk("abt_pulse", {29'h0, ap_abort, ap_req, ap_rdy}, 32'h5);
    cyc();
    chk("abt_pulse_end", {31'h0, ap_abort}, 32'h0);
    rd(1'b0, 2'd3);
    chk("abt_ack_discarded", bus_rdata, 32'hdeadbeef);
    chk("abt_no_sticky", {31'h0, dp_any_sticky_err}, 32'h0);

    // Power-up handshake; extra idle cycles cover the optional synchronisers.
    wr(1'b0, 2'd1, 32'h5000_0000);
    chk("pwrup_reqs", {30'h0, cdbgpwrupreq, csyspwrupreq}, 32'h3);
    rd(1'b0, 2'd1);
    chk("pwrup_noack", bus_rdata, 32'h50000000);
    cdbgpwrupack = 1'b1; csyspwrupack = 1'b1;
    repeat (3) cyc();
    rd(1'b0, 2'd1);
    chk("pwrup_ack", bus_rdata, 32'hf0000000);
    wr(1'b0, 2'd1, 32'h0000_0001);
    chk("orundetect", {29'h0, dp_orundetect, cdbgpwrupreq, csyspwrupreq}, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
